// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between the integer pipe (req 0) and the iterative/address unit (req 1).
// Optional: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req 0 wins) instead of round-robin.
module alu_share_arbiter #(
  parameter int unsigned DataSize  = 32,
  parameter int unsigned ALUopSize = 4,
  parameter int unsigned NumReq    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumReq-1:0]     req_valid,
  output logic [NumReq-1:0]     req_ready,
  input  logic [DataSize-1:0]   req0_src1,
  input  logic [DataSize-1:0]   req0_src2,
  input  logic [ALUopSize-1:0]  req0_op,
  input  logic [DataSize-1:0]   req1_src1,
  input  logic [DataSize-1:0]   req1_src2,
  input  logic [ALUopSize-1:0]  req1_op,
  output logic [NumReq-1:0]     resp_valid,
  input  logic [NumReq-1:0]     resp_ready,
  output logic [DataSize-1:0]   resp_data,
  output logic                  resp_zero,
  output logic [DataSize-1:0]   alu_src1,
  output logic [DataSize-1:0]   alu_src2,
  output logic [ALUopSize-1:0]  alu_type,
  output logic                  alu_rst,
  input  logic [DataSize-1:0]   alu_result,
  input  logic                  alu_zero
);

  localparam logic [ALUopSize-1:0] OpXor    = ALUopSize'(4);
  localparam logic [ALUopSize-1:0] OpMaxLeg = ALUopSize'(7);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e                 state_q;
  logic                   grant_q;
  logic [DataSize-1:0]    src1_q;
  logic [DataSize-1:0]    src2_q;
  logic [ALUopSize-1:0]   op_q;
  logic [DataSize-1:0]    resp_data_q;
  logic                   resp_zero_q;
  logic [NumReq-1:0]      resp_valid_q;
  logic                   alu_rst_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                   rr_ptr_q;
`endif

  logic [NumReq-1:0]      gnt_vec;
  logic                   gnt_idx;
  logic                   op_legal;

  // Grant is only offered while idle; the winner's operands are latched on the same edge.
  always_comb begin
    gnt_vec = '0;
    gnt_idx = 1'b0;
    if (state_q == StIdle) begin
      case (req_valid)
        2'b01: begin
          gnt_idx = 1'b0;
          gnt_vec = 2'b01;
        end
        2'b10: begin
          gnt_idx = 1'b1;
          gnt_vec = 2'b10;
        end
        2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          gnt_idx = 1'b0;
`else
          gnt_idx = rr_ptr_q;
`endif
          gnt_vec = gnt_idx ? 2'b10 : 2'b01;
        end
        default: begin
          gnt_idx = 1'b0;
          gnt_vec = '0;
        end
      endcase
    end
  end

  assign op_legal = (op_q <= OpMaxLeg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      op_q         <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_valid_q <= '0;
      alu_rst_q    <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|gnt_vec) begin
            src1_q    <= gnt_idx ? req1_src1 : req0_src1;
            src2_q    <= gnt_idx ? req1_src2 : req0_src2;
            op_q      <= gnt_idx ? req1_op : req0_op;
            grant_q   <= gnt_idx;
            alu_rst_q <= 1'b0;
            state_q   <= StExec;
          end
        end
        StExec: begin
          // Zero is only meaningful after XOR; illegal ops return an all-zero result.
          resp_data_q  <= op_legal ? alu_result : '0;
          resp_zero_q  <= (op_q == OpXor) && alu_zero;
          resp_valid_q <= grant_q ? 2'b10 : 2'b01;
          alu_rst_q    <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            state_q      <= StIdle;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= ~grant_q;
`endif
          end
        end
        default: begin
          resp_valid_q <= '0;
          alu_rst_q    <= 1'b1;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign req_ready  = gnt_vec;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign alu_type   = op_q;
  assign alu_rst    = alu_rst_q;

endmodule
